mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter: ADDR_W, 32, address width.
REQ-002 SHALL have parameter: DATA_W, 32, data width.
REQ-003 SHALL have port: clk  in  1  clock; reset reset, asynchronous, active-high; clock clk.
REQ-004 SHALL have port: reset  in  1  asynchronous active-high reset.
REQ-005 SHALL have port: if_valid  in  1  instruction-fetch read request (port 0).
REQ-006 SHALL have port: if_addr  in  ADDR_W  fetch address.
REQ-007 SHALL have port: if_done  out  1  one-cycle completion pulse, port 0.
REQ-008 SHALL have port: if_rdata  out  DATA_W  fetched word, valid with if_done.
REQ-009 SHALL have port: ls_valid  in  1  load/store request (port 1).
REQ-010 SHALL have port: ls_rw  in  1  1=read, 0=write.
REQ-011 SHALL have port: ls_addr  in  ADDR_W  load/store address.
REQ-012 SHALL have port: ls_wdata  in  DATA_W  store data.
REQ-013 SHALL have port: ls_done  out  1  one-cycle completion pulse, port 1.
REQ-014 SHALL have port: ls_rdata  out  DATA_W  load data, valid with ls_done.
REQ-015 SHALL have port: mem_valid  out  1  memory request strobe, held until mem_ready.
REQ-016 SHALL have port: mem_rw  out  1  1=read, 0=write.
REQ-017 SHALL have port: mem_addr / mem_wdata  out  ADDR_W / DATA_W  request fields.
REQ-018 SHALL have port: mem_rdata  in  DATA_W  read data, sampled when mem_ready=1.
REQ-019 SHALL have port: mem_ready  in  1  memory completion, sampled only while mem_valid=1.
REQ-020 SHALL have port: busy  out  1  high in any state except IDLE; owner  out  1  port holding the grant.

Function
REQ-021 SHALL implement FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE, all outputs registered.
REQ-022 IDLE: on any *_valid, SHALL select a winner and latch its addr/rw/wdata and owner, then go to ISSUE; otherwise stay.
REQ-023 Port 0 transfers SHALL always drive mem_rw=1.
REQ-024 ISSUE: SHALL assert mem_valid with latched fields, then go to WAIT.
REQ-025 WAIT: SHALL hold mem_valid and fields stable; on mem_ready=1, SHALL capture mem_rdata, drop mem_valid, and go to DONE.
REQ-026 DONE: SHALL pulse the owner's *_done for exactly one cycle with *_rdata, then return to IDLE; the other port's *_done SHALL stay 0.
REQ-027 Latency: request sampled at edge t gives mem_valid high after edge t+1; mem_ready at edge t+k gives *_done high after edge t+k+1; back-to-back grants are at least 4 cycles apart.
REQ-028 *_rdata SHALL hold its last value between pulses; for writes it SHALL be undefined-but-stable (hold previous).
REQ-029 Requester deasserting *_valid after latch SHALL NOT abort the transfer; done still pulses.
REQ-030 Requester SHALL treat *_done as acceptance; *_valid still high in the DONE cycle SHALL NOT be re-granted until IDLE re-samples.
REQ-031 mem_ready while mem_valid=0 SHALL be ignored.
REQ-032 No timeout: WAIT SHALL persist indefinitely without mem_ready.

Reset
REQ-033 Reset SHALL force IDLE and set mem_valid, mem_rw, mem_addr, mem_wdata, if_done, ls_done, if_rdata, ls_rdata, busy, and owner to 0, and set the round-robin pointer to 0.
REQ-034 Reset mid-transfer SHALL abandon it with no *_done pulse; the first grant after release SHALL follow REQ-022.

Configuration
REQ-035 With ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL grant the port not granted last (pointer updated on each grant).
REQ-036 Without ARB_ROUND_ROBIN_EN, port 1 (load/store) SHALL have fixed priority over port 0.

Structure
REQ-037 Package mem_arb_pkg SHALL hold the FSM state enum, MEM_READ=1/MEM_WRITE=0, and PORT_IF=0/PORT_LS=1 constants.
REQ-038 Winner selection SHALL be a sub-module arb_pick (inputs: two valids and last-grant pointer; output: winner index); it is the only logic affected by the macro.

Verification
REQ-039 Test: single fetch, if_addr=0x100, mem_ready after 3 WAIT cycles, mem_rdata=0xDEADBEEF -> mem_rw=1, mem_addr=0x100, if_done pulses once with if_rdata=0xDEADBEEF.
REQ-040 Test: store, ls_rw=0, ls_addr=0x40, ls_wdata=0x12345678 -> mem_rw=0 with those fields; ls_done pulses once; if_done stays 0.
REQ-041 Test: both valid continuously for 4 grants -> with macro the owner sequence is LS,IF,LS,IF (pointer 0 after reset); without it all 4 grants go to LS.
REQ-042 Test: reset asserted during WAIT -> all outputs 0 immediately, no done pulse; after release, a new fetch completes normally.
REQ-043 Test: mem_ready pulsed in IDLE, and if_valid dropped after ISSUE -> the pulse is ignored; the fetch still completes with one if_done.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Holds the FSM state enum, memory direction codes and port indices.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic MEM_READ  = 1'b1;
    localparam logic MEM_WRITE = 1'b0;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_LS = 1'b1;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Winner selection between the fetch port and the load/store port.
// Ports: req_if/req_ls (request valids), last (last granted port),
//        winner (selected port index; meaningful only when a request is up).
// Build option: ARB_ROUND_ROBIN_EN selects alternating grants on conflict;
//               otherwise load/store has fixed priority.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic req_if,
    input  logic req_ls,
    input  logic last,
    output logic winner
);

    always_comb begin
        // With no request the result is unused; holding 'last' keeps it stable.
        winner = last;
`ifdef ARB_ROUND_ROBIN_EN
        if (req_if && req_ls) begin
            winner = ~last;
        end else if (req_ls) begin
            winner = PORT_LS;
        end else if (req_if) begin
            winner = PORT_IF;
        end
`else
        if (req_ls) begin
            winner = PORT_LS;
        end else if (req_if) begin
            winner = PORT_IF;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: fetch (port 0, read-only) and load/store (port 1)
// share one memory request channel through an IDLE/ISSUE/WAIT/DONE FSM.
// Ports: clk, reset (async, active-high); if_* fetch request/done/rdata;
//        ls_* load/store request/done/rdata; mem_* memory channel;
//        busy (not IDLE), owner (granted port). All outputs are registered.
// Build option: ARB_ROUND_ROBIN_EN (see arb_pick).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_valid,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_valid,
    input  logic              ls_rw,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_done,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mem_valid,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              owner
);

    state_t            state_q, state_d;
    logic              mem_valid_q, mem_valid_d;
    logic              mem_rw_q, mem_rw_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rbuf_q, rbuf_d;
    logic              if_done_q, if_done_d;
    logic              ls_done_q, ls_done_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
    logic              busy_q, busy_d;
    logic              owner_q, owner_d;
    logic              rr_q, rr_d;
    logic              win;

    arb_pick u_pick (
        .req_if (if_valid),
        .req_ls (ls_valid),
        .last   (rr_q),
        .winner (win)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            mem_valid_q <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rbuf_q      <= '0;
            if_done_q   <= 1'b0;
            ls_done_q   <= 1'b0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
            busy_q      <= 1'b0;
            owner_q     <= 1'b0;
            rr_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_valid_q <= mem_valid_d;
            mem_rw_q    <= mem_rw_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rbuf_q      <= rbuf_d;
            if_done_q   <= if_done_d;
            ls_done_q   <= ls_done_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
            busy_q      <= busy_d;
            owner_q     <= owner_d;
            rr_q        <= rr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_valid_d = mem_valid_q;
        mem_rw_d    = mem_rw_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rbuf_d      = rbuf_q;
        if_done_d   = 1'b0;
        ls_done_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;
        owner_d     = owner_q;
        rr_d        = rr_q;

        unique case (state_q)
            S_IDLE: begin
                if (if_valid || ls_valid) begin
                    owner_d = win;
                    rr_d    = win;
                    if (win == PORT_LS) begin
                        mem_rw_d    = ls_rw ? MEM_READ : MEM_WRITE;
                        mem_addr_d  = ls_addr;
                        mem_wdata_d = ls_wdata;
                    end else begin
                        mem_rw_d    = MEM_READ;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                    end
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_valid_d = 1'b1;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                // mem_ready only counts once the strobe is actually out.
                if (mem_valid_q && mem_ready) begin
                    rbuf_d      = mem_rdata;
                    mem_valid_d = 1'b0;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (owner_q == PORT_LS) begin
                    ls_done_d = 1'b1;
                    if (mem_rw_q == MEM_READ) begin
                        ls_rdata_d = rbuf_q;
                    end
                end else begin
                    if_done_d  = 1'b1;
                    if_rdata_d = rbuf_q;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign mem_valid = mem_valid_q;
    assign mem_rw    = mem_rw_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_done   = if_done_q;
    assign ls_done   = ls_done_q;
    assign if_rdata  = if_rdata_q;
    assign ls_rdata  = ls_rdata_q;
    assign busy      = busy_q;
    assign owner     = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected memory
// requests and done pulses; separate monitors pop and compare them.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_valid, ls_valid, ls_rw;
    logic [31:0] if_addr, ls_addr, ls_wdata;
    logic        if_done, ls_done;
    logic [31:0] if_rdata, ls_rdata;
    logic        mem_valid, mem_rw, mem_ready;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy, owner;
    logic        resp_ready = 1'b0;
    logic        poke_ready = 1'b0;

    assign mem_ready = resp_ready | poke_ready;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_valid  (if_valid),
        .if_addr   (if_addr),
        .if_done   (if_done),
        .if_rdata  (if_rdata),
        .ls_valid  (ls_valid),
        .ls_rw     (ls_rw),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_done   (ls_done),
        .ls_rdata  (ls_rdata),
        .mem_valid (mem_valid),
        .mem_rw    (mem_rw),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .busy      (busy),
        .owner     (owner)
    );

    typedef struct {
        logic        port;
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          wait_n;
        logic [31:0] rdata;
    } req_t;

    typedef struct {
        logic        port;
        logic [31:0] rdata;
    } done_t;

    req_t  req_q[$];
    done_t done_q[$];
    int    n_pass = 0;
    int    n_total = 0;
    logic [31:0] last_if_rd = '0;
    logic [31:0] last_ls_rd = '0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail(input string name);
        n_total++;
        $display("FAIL %s", name);
    endtask

    task automatic expect_txn(input logic port, input logic rw,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input int wait_n, input logic [31:0] rdata);
        req_q.push_back('{port, rw, addr, wdata, wait_n, rdata});
        if (rw) begin
            if (port) last_ls_rd = rdata;
            else      last_if_rd = rdata;
        end
        done_q.push_back('{port, port ? last_ls_rd : last_if_rd});
    endtask

    task automatic wait_dones(input int n, input int budget);
        int got = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (if_done || ls_done) begin
                got++;
                if (got == n) break;
            end
        end
        if (got < n) fail("done_timeout");
    endtask

    task automatic wait_mem_valid(input int budget);
        bit seen = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (mem_valid) begin
                seen = 1;
                break;
            end
        end
        if (!seen) fail("mem_valid_timeout");
    endtask

    // Memory model: checks request fields, answers after wait_n WAIT cycles.
    initial begin
        req_t cur;
        int   cnt;
        cnt = 0;
        mem_rdata = '0;
        cur = '{1'b0, 1'b1, 32'h0, 32'h0, 1, 32'h0};
        forever begin
            @(negedge clk);
            if (reset) begin
                cnt = 0;
                resp_ready = 1'b0;
            end else if (mem_valid && !resp_ready) begin
                if (cnt == 0) begin
                    if (req_q.size() == 0) fail("mem_unexpected");
                    else cur = req_q.pop_front();
                    chk("owner", owner, cur.port);
                    chk("busy", busy, 1);
                end
                chk("mem_rw", mem_rw, cur.rw);
                chk("mem_addr", mem_addr, cur.addr);
                if (!cur.rw) chk("mem_wdata", mem_wdata, cur.wdata);
                cnt++;
                if (cnt >= cur.wait_n) begin
                    mem_rdata  = cur.rdata;
                    resp_ready = 1'b1;
                    @(negedge clk);
                    resp_ready = 1'b0;
                    cnt = 0;
                    if (!reset) begin
                        chk("valid_drop", mem_valid, 0);
                        @(negedge clk);
                        if (!reset) chk("done_latency", if_done | ls_done, 1);
                    end
                end
            end
        end
    end

    // Done monitor: every pulse must match the head of done_q.
    initial begin
        done_t e;
        forever begin
            @(negedge clk);
            if (!reset && (if_done || ls_done)) begin
                chk("done_onehot", if_done & ls_done, 0);
                if (done_q.size() == 0) begin
                    fail("done_unexpected");
                end else begin
                    e = done_q.pop_front();
                    chk("done_port", ls_done, e.port);
                    chk(e.port ? "ls_rdata" : "if_rdata",
                        e.port ? ls_rdata : if_rdata, e.rdata);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog");
    end

    initial begin
        logic port;
        if_valid = 0; if_addr = '0;
        ls_valid = 0; ls_rw = 0; ls_addr = '0; ls_wdata = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_mem_rw", mem_rw, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_if_done", if_done, 0);
        chk("rst_ls_done", ls_done, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_ls_rdata", ls_rdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        reset = 0;

        // Single fetch, 3 WAIT cycles
        expect_txn(1'b0, 1'b1, 32'h100, 32'h0, 3, 32'hDEADBEEF);
        @(negedge clk);
        if_valid = 1; if_addr = 32'h100;
        @(negedge clk);
        chk("lat_issue_valid", mem_valid, 0);
        chk("lat_issue_busy", busy, 1);
        @(negedge clk);
        chk("lat_mem_valid", mem_valid, 1);
        wait_dones(1, 100);
        if_valid = 0;

        // Store, then load
        expect_txn(1'b1, 1'b0, 32'h40, 32'h12345678, 2, 32'h0);
        @(negedge clk);
        ls_valid = 1; ls_rw = 0; ls_addr = 32'h40; ls_wdata = 32'h12345678;
        wait_dones(1, 100);
        ls_valid = 0;
        chk("if_rdata_hold", if_rdata, 32'hDEADBEEF);

        expect_txn(1'b1, 1'b1, 32'h44, 32'h0, 1, 32'hCAFEF00D);
        @(negedge clk);
        ls_valid = 1; ls_rw = 1; ls_addr = 32'h44;
        wait_dones(1, 100);
        ls_valid = 0;

        // Both ports requesting continuously for 4 grants
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        last_if_rd = '0;
        last_ls_rd = '0;
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            port = (i % 2 == 0) ? 1'b1 : 1'b0;
`else
            port = 1'b1;
`endif
            expect_txn(port, 1'b1, port ? 32'h300 : 32'h200, 32'h0, 1,
                       32'hA0000000 + 32'(i));
        end
        @(negedge clk);
        if_valid = 1; if_addr = 32'h200;
        ls_valid = 1; ls_rw = 1; ls_addr = 32'h300; ls_wdata = '0;
        wait_dones(4, 200);
        if_valid = 0; ls_valid = 0;

        // Reset during WAIT abandons the transfer
        req_q.push_back('{1'b0, 1'b1, 32'h400, 32'h0, 1000, 32'h0});
        @(negedge clk);
        if_valid = 1; if_addr = 32'h400;
        wait_mem_valid(20);
        repeat (2) @(negedge clk);
        #2 reset = 1;
        #1;
        chk("arst_mem_valid", mem_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_mem_addr", mem_addr, 0);
        chk("arst_mem_rw", mem_rw, 0);
        chk("arst_if_rdata", if_rdata, 0);
        if_valid = 0;
        repeat (2) @(negedge clk);
        reset = 0;
        last_if_rd = '0;
        last_ls_rd = '0;
        expect_txn(1'b0, 1'b1, 32'h500, 32'h0, 2, 32'h55AA55AA);
        @(negedge clk);
        if_valid = 1; if_addr = 32'h500;
        wait_dones(1, 100);
        if_valid = 0;

        // Stray mem_ready in IDLE and ISSUE; requester drops valid early
        @(negedge clk);
        poke_ready = 1;
        @(negedge clk);
        poke_ready = 0;
        chk("idle_ready_busy", busy, 0);
        chk("idle_ready_valid", mem_valid, 0);
        expect_txn(1'b0, 1'b1, 32'h600, 32'h0, 2, 32'h0BADF00D);
        if_valid = 1; if_addr = 32'h600;
        @(negedge clk);
        poke_ready = 1;
        @(negedge clk);
        poke_ready = 0;
        if_valid = 0;
        chk("issue_ready_valid", mem_valid, 1);
        wait_dones(1, 100);
        repeat (8) @(negedge clk);
        chk("final_if_rdata", if_rdata, 32'h0BADF00D);
        chk("req_q_empty", req_q.size(), 0);
        chk("done_q_empty", done_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
